dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter: WBUF_DEPTH, default 4, posted-write buffer entries; power of two, at least 2.
REQ-002 Parameter: TIMEOUT, default 255, ext_ack wait limit in cycles; 0 disables the timeout.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset; assertion clears all state immediately.
REQ-005 Port: data_addr  in  32  processor data byte address.
REQ-006 Port: data_out  in  32  processor store data.
REQ-007 Port: mem_read, mem_write  in  1 each  processor access strobes.
REQ-008 Port: data_in  out  32  load data returned to the processor.
REQ-009 Port: stall  out  1  processor must hold PC and request while high.
REQ-010 Port: ext_req, ext_we  out  1 each  external request and write-enable.
REQ-011 Port: ext_addr  out  32  external word address (bits [1:0] forced 0).
REQ-012 Port: ext_wdata  out  32  external write data.
REQ-013 Port: ext_ack  in  1  external completion strobe.
REQ-014 Port: ext_rdata  in  32  external read data, valid with ext_ack.
REQ-015 Port: bus_err  out  1  sticky timeout flag.

Function
REQ-016 FSM states: IDLE, WR_ISSUE, RD_DRAIN, RD_ISSUE, RD_DONE.
REQ-017 Write, buffer not full: push {addr, data} into the buffer on the same edge; stall=0 that cycle.
REQ-018 Write, buffer full: stall=1 until count<WBUF_DEPTH; a pop in the same cycle does not release stall (full is registered).
REQ-019 IDLE with buffer non-empty: go to WR_ISSUE next edge; ext_req=1, ext_we=1, with buffer-head addr/data as registered outputs.
REQ-020 WR_ISSUE: hold ext_* stable until ext_ack=1; on that edge pop the head and drop ext_req.
REQ-021 After a write completes: go to WR_ISSUE if the buffer is still non-empty, otherwise to IDLE.
REQ-022 Read: stall=1 combinationally from the first cycle mem_read=1 until the RD_DONE cycle.
REQ-023 Read with a non-empty buffer: enter RD_DRAIN and drain all writes first (strict ordering); enter RD_ISSUE once empty.
REQ-024 RD_ISSUE: ext_req=1, ext_we=0, ext_addr={data_addr[31:2],2'b00}; on ext_ack capture ext_rdata into rd_buf and go to RD_DONE.
REQ-025 RD_DONE, one cycle: stall=0, data_in=rd_buf; next edge returns to IDLE.
REQ-026 data_in holds its last value at all other times.
REQ-027 mem_read=1 and mem_write=1 together: serve as a read and ignore the write.
REQ-028 ext_ack is ignored while ext_req=0.
REQ-029 Back-to-back: ext_req may reassert on the edge after an ack.
REQ-030 Buffer count arithmetic: push and pop on the same edge leave count unchanged; pointers wrap modulo WBUF_DEPTH.
REQ-031 Timeout: ext_req high for TIMEOUT cycles without ack sets bus_err=1 and completes the transaction; a read returns 32'hDEAD_BEEF.

Reset
REQ-032 Reset asserted (reset=0) gives: ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, data_in=0, stall=0, bus_err=0.
REQ-033 Reset also empties the buffer, zeroes the timeout counter and sets FSM=IDLE.
REQ-034 Reset mid-transaction abandons the outstanding access; a late ext_ack after release is ignored.

Structure
REQ-035 Package dmem_pkg holds the FSM state enum, the write-entry struct {addr[31:0], data[31:0]} and the DEADBEEF constant.
REQ-036 Sub-module wbuf_fifo (parameterised depth; push/pop/full/empty/count) holds the posted-write buffer.
REQ-037 Total size is about 200 RTL lines.

Verification
REQ-038 Single write 0x10<-0xA5A5A5A5, ext_ack 2 cycles after ext_req -> stall never 1; one ext transaction with we=1, addr 0x10; buffer empty afterwards.
REQ-039 Five consecutive writes with ext_ack held 0 -> stall=1 on the 5th write; released the cycle after the first ack.
REQ-040 Write 0x20<-7 then immediate read 0x20, ext memory echoes -> read issued only after the write ack; data_in=7 in the RD_DONE cycle.
REQ-041 Read 0x23 -> ext_addr=0x20.
REQ-042 Read with ext_ack never asserted, TIMEOUT=8 -> bus_err=1 after 8 cycles; data_in=0xDEADBEEF.
REQ-043 reset pulsed low during RD_ISSUE -> all outputs zero immediately; ack one cycle after release produces no state change.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory bridge: FSM encoding, posted-write entry
// and the value returned for reads that never received an acknowledge.
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_DRAIN,
        RD_ISSUE,
        RD_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wentry_t;

    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    // The external bus only understands word addresses.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: a power-of-two circular FIFO of {addr, data} entries.
// Full and empty come from the registered count only.
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  wentry_t                 push_entry,
    input  logic                    pop,
    output wentry_t                 head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wentry_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges a single-cycle processor data port onto a request/acknowledge bus,
// posting writes into a small buffer and stalling reads until it has drained.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_in,
    output logic        stall,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic        ext_ack,
    input  logic [31:0] ext_rdata,
    output logic        bus_err
);

    localparam int CW = $clog2(WBUF_DEPTH) + 1;

    state_t          state;
    state_t          next_state;
    wentry_t         head;
    wentry_t         wr_entry;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            more_writes;
    logic            load_wr;
    logic            load_rd;
    logic            drop_req;
    logic            capture;
    logic            timed_out;
    logic            done;
    logic [31:0]     tcount;

    // A simultaneous read wins; the write is simply not accepted.
    assign push     = mem_write && !mem_read && !full;
    assign wr_entry = '{addr: data_addr, data: data_out};

    assign more_writes = (count > CW'(1)) || push;
    assign timed_out   = (TIMEOUT != 0) && ext_req && !ext_ack
                         && (tcount == 32'(TIMEOUT - 1));
    assign done        = ext_req && (ext_ack || timed_out);

    assign stall = reset && ((mem_read && state != RD_DONE)
                             || (mem_write && !mem_read && full));

    wbuf_fifo #(
        .DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Issue states spend one cycle with ext_req low after each completion,
    // during which the next request is loaded.
    always_comb begin
        next_state = state;
        load_wr    = 1'b0;
        load_rd    = 1'b0;
        drop_req   = 1'b0;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read) begin
                    if (!empty) begin
                        next_state = RD_DRAIN;
                        load_wr    = 1'b1;
                    end else begin
                        next_state = RD_ISSUE;
                        load_rd    = 1'b1;
                    end
                end else if (!empty) begin
                    next_state = WR_ISSUE;
                    load_wr    = 1'b1;
                end
            end
            WR_ISSUE: begin
                if (!ext_req) begin
                    load_wr = 1'b1;
                end else if (done) begin
                    pop      = 1'b1;
                    drop_req = 1'b1;
                    if (!more_writes) next_state = IDLE;
                end
            end
            RD_DRAIN: begin
                if (!ext_req) begin
                    load_wr = 1'b1;
                end else if (done) begin
                    pop      = 1'b1;
                    drop_req = 1'b1;
                    if (!more_writes) next_state = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (!ext_req) begin
                    load_rd = 1'b1;
                end else if (done) begin
                    capture    = 1'b1;
                    drop_req   = 1'b1;
                    next_state = RD_DONE;
                end
            end
            RD_DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
        end else if (load_wr) begin
            ext_req   <= 1'b1;
            ext_we    <= 1'b1;
            ext_addr  <= word_addr(head.addr);
            ext_wdata <= head.data;
        end else if (load_rd) begin
            ext_req   <= 1'b1;
            ext_we    <= 1'b0;
            ext_addr  <= word_addr(data_addr);
        end else if (drop_req) begin
            ext_req   <= 1'b0;
        end
    end

    // data_in doubles as the read buffer, so it holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcount  <= '0;
            data_in <= '0;
            bus_err <= 1'b0;
        end else begin
            if (!ext_req || done) tcount <= '0;
            else                  tcount <= tcount + 32'd1;
            if (capture)   data_in <= ext_ack ? ext_rdata : DEADBEEF;
            if (timed_out) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: table-driven single accesses plus
// hand-written sequences for buffer-full, ordering, timeout and reset cases.
module tb_dmem_bridge;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_RW} op_t;

    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_out = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_in;
    logic        stall;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack = 1'b0;
    logic [31:0] ext_rdata = '0;
    logic        bus_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_ack_cyc = -100;
    bit          ack_en = 1'b1;
    bit          manual_ack = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] ext_mem [logic [31:0]];
    txn_t        exp_q [$];
    txn_t        mon_t;
    vec_t        vecs [9];
    int          n;
    int          hi;
    int          rel;

    dmem_bridge #(
        .WBUF_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_addr (data_addr),
        .data_out  (data_out),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_in   (data_in),
        .stall     (stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // External memory: echoes writes back on later reads, ack after ack_delay cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (!ack_en) begin
            wait_cnt = 0;
            ext_ack  = manual_ack;
            if (manual_ack) ext_rdata = 32'h0BAD_F00D;
        end else if (ext_ack) begin
            ext_ack = 1'b0;
        end else if (ext_req) begin
            if (wait_cnt >= ack_delay) begin
                wait_cnt = 0;
                if (ext_we) ext_mem[ext_addr] = ext_wdata;
                else ext_rdata = ext_mem.exists(ext_addr) ? ext_mem[ext_addr] : 32'h0;
                ext_ack = 1'b1;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset && ext_req && ext_ack) begin
            last_ack_cyc = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_txn: got we=%0b addr %h, expected no transaction",
                         ext_we, ext_addr);
            end else begin
                mon_t = exp_q.pop_front();
                check_output("txn_we", 32'(ext_we), 32'(mon_t.we));
                check_output("txn_addr", ext_addr, mon_t.addr);
                if (mon_t.we) check_output("txn_wdata", ext_wdata, mon_t.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no $finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_output("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check_output("idle_no_req", 32'(ext_req), 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        int k;
        ack_delay = v.delay;
        @(posedge clk);
        #1;
        data_addr = v.addr;
        data_out  = v.wdata;
        if (v.op == OP_WR) begin
            mem_write = 1'b1;
            exp_q.push_back('{we: 1'b1, addr: v.exp_addr, wdata: v.wdata});
            @(negedge clk);
            check_output("wr_stall", 32'(stall), 32'd0);
            @(posedge clk);
            #1;
            mem_write = 1'b0;
        end else begin
            mem_read  = 1'b1;
            mem_write = (v.op == OP_RW);
            exp_q.push_back('{we: 1'b0, addr: v.exp_addr, wdata: 32'h0});
            @(negedge clk);
            check_output("rd_stall_first", 32'(stall), 32'd1);
            k = 0;
            while (stall && k < 40) begin
                @(negedge clk);
                k++;
            end
            check_output("rd_complete", 32'(stall), 32'd0);
            check_output("rd_data", data_in, v.exp_rdata);
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        vecs[0] = '{OP_WR, 32'h0000_0010, 32'hA5A5_A5A5, 2, 32'h0000_0010, 32'h0};
        vecs[1] = '{OP_WR, 32'h0000_0044, 32'h1234_5678, 0, 32'h0000_0044, 32'h0};
        vecs[2] = '{OP_RD, 32'h0000_0010, 32'h0,         1, 32'h0000_0010, 32'hA5A5_A5A5};
        vecs[3] = '{OP_RD, 32'h0000_0047, 32'h0,         3, 32'h0000_0044, 32'h1234_5678};
        vecs[4] = '{OP_WR, 32'h0000_002C, 32'hCAFE_F00D, 1, 32'h0000_002C, 32'h0};
        vecs[5] = '{OP_RW, 32'h0000_002C, 32'hBAD0_BAD0, 0, 32'h0000_002C, 32'hCAFE_F00D};
        vecs[6] = '{OP_RD, 32'h0000_002E, 32'h0,         2, 32'h0000_002C, 32'hCAFE_F00D};
        vecs[7] = '{OP_WR, 32'h0000_0023, 32'h0000_0055, 1, 32'h0000_0020, 32'h0};
        vecs[8] = '{OP_RD, 32'h0000_0021, 32'h0,         1, 32'h0000_0020, 32'h0000_0055};

        // Reset held with a read pending: stall must still be low.
        mem_read = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_ext_req", 32'(ext_req), 32'd0);
        check_output("rst_ext_we", 32'(ext_we), 32'd0);
        check_output("rst_ext_addr", ext_addr, 32'd0);
        check_output("rst_ext_wdata", ext_wdata, 32'd0);
        check_output("rst_data_in", data_in, 32'd0);
        check_output("rst_stall", 32'(stall), 32'd0);
        check_output("rst_bus_err", 32'(bus_err), 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

        // Five writes against a stalled bus: the fifth sees a full buffer.
        ack_en = 1'b0;
        last_ack_cyc = -100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            data_addr = 32'h100 + 32'(4 * i);
            data_out  = 32'h5000 + 32'(i);
            mem_write = 1'b1;
            @(negedge clk);
            if (i < 4) begin
                check_output("burst_stall", 32'(stall), 32'd0);
                exp_q.push_back('{we: 1'b1, addr: data_addr, wdata: data_out});
            end
        end
        check_output("full_stall", 32'(stall), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check_output("full_hold", 32'(stall), 32'd1);
        end
        ack_delay = 0;
        ack_en    = 1'b1;
        rel = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall) begin
                rel = cyc;
                break;
            end
        end
        check_output("full_release_cycle", 32'(rel), 32'(last_ack_cyc + 1));
        exp_q.push_back('{we: 1'b1, addr: data_addr, wdata: data_out});
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        wait_idle();

        // Write immediately followed by a read of the same word.
        ack_delay = 2;
        @(posedge clk);
        #1;
        data_addr = 32'h20;
        data_out  = 32'h7;
        mem_write = 1'b1;
        exp_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h7});
        @(negedge clk);
        check_output("raw_wr_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b1;
        exp_q.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        @(negedge clk);
        check_output("raw_rd_stall", 32'(stall), 32'd1);
        n = 0;
        while (stall && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_output("raw_rd_complete", 32'(stall), 32'd0);
        check_output("raw_rd_data", data_in, 32'h7);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        data_addr = 32'h0;
        @(negedge clk);
        check_output("data_in_hold", data_in, 32'h7);
        wait_idle();

        // Read that is never acknowledged.
        ack_en = 1'b0;
        check_output("bus_err_clear", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        data_addr = 32'h80;
        mem_read  = 1'b1;
        n  = 0;
        hi = 0;
        @(negedge clk);
        while (stall && n < 40) begin
            if (ext_req) hi++;
            @(negedge clk);
            n++;
        end
        check_output("timeout_cycles", 32'(hi), 32'd8);
        check_output("timeout_bus_err", 32'(bus_err), 32'd1);
        check_output("timeout_data", data_in, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        check_output("timeout_err_sticky", 32'(bus_err), 32'd1);

        // Reset pulsed while a read is outstanding, then a stray acknowledge.
        @(posedge clk);
        #1;
        data_addr = 32'h40;
        mem_read  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ext_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("midrst_req_up", 32'(ext_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_ext_req", 32'(ext_req), 32'd0);
        check_output("midrst_ext_we", 32'(ext_we), 32'd0);
        check_output("midrst_ext_addr", ext_addr, 32'd0);
        check_output("midrst_ext_wdata", ext_wdata, 32'd0);
        check_output("midrst_data_in", data_in, 32'd0);
        check_output("midrst_stall", 32'(stall), 32'd0);
        check_output("midrst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("late_ack_req", 32'(ext_req), 32'd0);
            check_output("late_ack_data", data_in, 32'd0);
            check_output("late_ack_stall", 32'(stall), 32'd0);
            check_output("late_ack_err", 32'(bus_err), 32'd0);
        end

        // The bridge must still work after the abandoned access.
        ack_en = 1'b1;
        apply_stimulus('{OP_WR, 32'h48, 32'h600D_600D, 1, 32'h48, 32'h0});
        apply_stimulus('{OP_RD, 32'h48, 32'h0,         0, 32'h48, 32'h600D_600D});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
